// File: rtl/qdr_bram_responder_pkg.sv
// Shared QDR user-port definitions: beat/burst widths and calibration state codes.
// Also used by the CPU-side QDR interface.
package qdr_bram_responder_pkg;
  localparam int QDR_BEAT_W  = 36;
  localparam int QDR_BE_W    = 4;
  localparam int QDR_BURST_W = 72;
  localparam int QDR_LANES   = 8;

  typedef enum logic [1:0] {
    CAL_RESET = 2'd0,
    CAL_RUN   = 2'd1,
    CAL_READY = 2'd2,
    CAL_FAIL  = 2'd3
  } cal_state_t;

  // Beat0 of a write, held until beat1 arrives
  typedef struct packed {
    logic [QDR_BEAT_W-1:0] beat0;
    logic [QDR_BE_W-1:0]   be0;
  } wr_hold_t;
endpackage

// File: rtl/qdr_bram_72.sv
// Simple dual-port 72-bit BRAM with 9-bit lane write enables and registered read.
// Read-first on same-address collision; no reset on the array or read register.
module qdr_bram_72
  import qdr_bram_responder_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                   i_clk,
  input  logic [QDR_LANES-1:0]   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [QDR_BURST_W-1:0] i_wdata,
  input  logic                   i_re,
  input  logic [AW-1:0]          i_raddr,
  output logic [QDR_BURST_W-1:0] o_rdata
);
  logic [QDR_BURST_W-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < QDR_LANES; l++)
      if (i_we[l]) r_mem[i_waddr][l*9 +: 9] <= i_wdata[l*9 +: 9];
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/qdr_bram_responder.sv
// QDR user-port responder backed by BRAM: emulates calibration, 2-beat write capture,
// and fixed-latency 2-beat read bursts, with a saturating protocol-error counter.
module qdr_bram_responder
  import qdr_bram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = 22,
  parameter int MEM_AW         = 10,
  parameter int CAL_CYCLES     = 1024,
  parameter int RD_LATENCY     = 8,
  parameter bit FORCE_CAL_FAIL = 1'b0
) (
  input  logic                  qdr_clk_i,
  input  logic                  qdr_rst_i,
  output logic                  qdr_phy_rdy,
  output logic                  qdr_cal_fail,
  input  logic [ADDR_WIDTH-1:0] qdr_addr,
  input  logic                  qdr_wr_en,
  input  logic [QDR_BEAT_W-1:0] qdr_wr_data,
  input  logic [QDR_BE_W-1:0]   qdr_wr_be,
  input  logic                  qdr_rd_en,
  output logic [QDR_BEAT_W-1:0] qdr_rd_data,
  output logic                  qdr_rd_dvld,
  output logic [15:0]           dbg_err_cnt
);
  localparam int CW = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;

  cal_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cal_cnt;
  logic w_ready;

  always_ff @(posedge qdr_clk_i) begin
    if (qdr_rst_i) begin
      r_state   <= CAL_RESET;
      r_cal_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cal_cnt <= (r_state == CAL_RUN) ? r_cal_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CAL_RESET: w_state_nxt = CAL_RUN;
      CAL_RUN:   if (r_cal_cnt == CW'(CAL_CYCLES - 1))
                   w_state_nxt = FORCE_CAL_FAIL ? CAL_FAIL : CAL_READY;
      default:   w_state_nxt = r_state;
    endcase
  end

  assign w_ready      = (r_state == CAL_READY);
  assign qdr_phy_rdy  = w_ready;
  assign qdr_cal_fail = (r_state == CAL_FAIL);

  // Write capture: beat0 held one cycle, whole word commits with beat1
  logic              r_wr_pend;
  wr_hold_t          r_wr_hold;
  logic [MEM_AW-1:0] r_wr_addr;
  logic              w_wr_ok, w_wr_err;
  logic [QDR_LANES-1:0] w_we;

  assign w_wr_ok  = qdr_wr_en & w_ready & ~r_wr_pend;
  assign w_wr_err = qdr_wr_en & ~w_wr_ok;
  assign w_we     = r_wr_pend ? {qdr_wr_be, r_wr_hold.be0} : '0;

  always_ff @(posedge qdr_clk_i) begin
    if (qdr_rst_i) r_wr_pend <= 1'b0;
    else           r_wr_pend <= w_wr_ok;
  end

  always_ff @(posedge qdr_clk_i) begin
    if (w_wr_ok) begin
      r_wr_addr       <= qdr_addr[MEM_AW-1:0];
      r_wr_hold.beat0 <= qdr_wr_data;
      r_wr_hold.be0   <= qdr_wr_be;
    end
  end

  // Reads: an accepted read blocks the next cycle so beat0 never lands on beat1
  logic [RD_LATENCY-2:0]  r_vld_pipe;
  logic                   w_rd_ok, w_rd_err;
  logic [QDR_BURST_W-1:0] w_q, w_src;

  assign w_rd_ok  = qdr_rd_en & w_ready & ~r_vld_pipe[0];
  assign w_rd_err = qdr_rd_en & ~w_rd_ok;

  qdr_bram_72 #(.AW(MEM_AW)) u_bram (
    .i_clk   (qdr_clk_i),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata ({qdr_wr_data, r_wr_hold.beat0}),
    .i_re    (w_rd_ok),
    .i_raddr (qdr_addr[MEM_AW-1:0]),
    .o_rdata (w_q)
  );

  always_ff @(posedge qdr_clk_i) begin
    if (qdr_rst_i) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[0] <= w_rd_ok;
      for (int k = 1; k < RD_LATENCY - 1; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  // Data follows valid; BRAM output already counts as the first stage
  if (RD_LATENCY == 2) begin : g_dp0
    assign w_src = w_q;
  end else begin : g_dp
    logic [QDR_BURST_W-1:0] r_dp [RD_LATENCY-2];
    always_ff @(posedge qdr_clk_i) begin
      r_dp[0] <= w_q;
      for (int k = 1; k < RD_LATENCY - 2; k++) r_dp[k] <= r_dp[k-1];
    end
    assign w_src = r_dp[RD_LATENCY-3];
  end

  logic                  r_dvld;
  logic [QDR_BEAT_W-1:0] r_rd_data, r_hi;

  always_ff @(posedge qdr_clk_i) begin
    if (qdr_rst_i) begin
      r_dvld    <= 1'b0;
      r_rd_data <= '0;
      r_hi      <= '0;
    end else if (r_vld_pipe[RD_LATENCY-2]) begin
      r_dvld    <= 1'b1;
      r_rd_data <= w_src[QDR_BEAT_W-1:0];
      r_hi      <= w_src[QDR_BURST_W-1:QDR_BEAT_W];
    end else begin
      r_dvld    <= 1'b0;
      r_rd_data <= r_dvld ? r_hi : '0;
    end
  end

  assign qdr_rd_dvld = r_dvld;
  assign qdr_rd_data = r_rd_data;

  logic [15:0] r_err;
  logic [16:0] w_err_sum;
  assign w_err_sum = {1'b0, r_err} + 17'(w_rd_err) + 17'(w_wr_err);

  always_ff @(posedge qdr_clk_i) begin
    if (qdr_rst_i) r_err <= '0;
    else           r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  assign dbg_err_cnt = r_err;

  // Upper address bits alias onto the BRAM index
  if (ADDR_WIDTH > MEM_AW) begin : g_alias
    logic w_unused_addr;
    assign w_unused_addr = ^qdr_addr[ADDR_WIDTH-1:MEM_AW];
  end
endmodule

// File: tb/tb_qdr_bram_responder.sv
// Directed bench for qdr_bram_responder: calibration timing, bursts, lane enables,
// read/write collisions, protocol errors and reset mid-read.
module tb_qdr_bram_responder;
  localparam int L = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] addr;
  logic        wr_en, rd_en;
  logic [35:0] wr_data;
  logic [3:0]  wr_be;
  logic        phy_rdy, cal_fail, dvld;
  logic [35:0] rd_data;
  logic [15:0] err;
  logic        f_phy_rdy, f_cal_fail, f_dvld;
  logic [35:0] f_rd_data;
  logic [15:0] f_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qdr_bram_responder #(.CAL_CYCLES(16), .RD_LATENCY(L)) dut (
    .qdr_clk_i(clk), .qdr_rst_i(rst), .qdr_phy_rdy(phy_rdy), .qdr_cal_fail(cal_fail),
    .qdr_addr(addr), .qdr_wr_en(wr_en), .qdr_wr_data(wr_data), .qdr_wr_be(wr_be),
    .qdr_rd_en(rd_en), .qdr_rd_data(rd_data), .qdr_rd_dvld(dvld), .dbg_err_cnt(err)
  );

  qdr_bram_responder #(.CAL_CYCLES(16), .RD_LATENCY(L), .FORCE_CAL_FAIL(1'b1)) dut_f (
    .qdr_clk_i(clk), .qdr_rst_i(rst), .qdr_phy_rdy(f_phy_rdy), .qdr_cal_fail(f_cal_fail),
    .qdr_addr(22'd0), .qdr_wr_en(1'b0), .qdr_wr_data(36'd0), .qdr_wr_be(4'd0),
    .qdr_rd_en(1'b0), .qdr_rd_data(f_rd_data), .qdr_rd_dvld(f_dvld), .dbg_err_cnt(f_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wr_burst(input logic [21:0] a, input logic [35:0] b0, input logic [3:0] be0,
                          input logic [35:0] b1, input logic [3:0] be1);
    wr_en = 1'b1; addr = a; wr_data = b0; wr_be = be0;
    tick;
    wr_en = 1'b0; wr_data = b1; wr_be = be1;
    tick;
    wr_data = '0; wr_be = '0;
  endtask

  task automatic rd_burst(input logic [21:0] a, input logic [35:0] lo, input logic [35:0] hi,
                          input string tag);
    rd_en = 1'b1; addr = a;
    tick;
    rd_en = 1'b0;
    repeat (L - 2) tick;
    chk({tag, "_pre"}, 72'(dvld), 72'd0);
    tick;
    chk({tag, "_dv0"}, 72'(dvld), 72'd1);
    chk({tag, "_b0"}, 72'(rd_data), 72'(lo));
    tick;
    chk({tag, "_dv1"}, 72'(dvld), 72'd0);
    chk({tag, "_b1"}, 72'(rd_data), 72'(hi));
    tick;
    chk({tag, "_idle"}, 72'(rd_data), 72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int wt;
    rst = 1'b1; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; wr_be = '0;
    repeat (3) tick;
    chk("rst_rdy",  72'(phy_rdy),  72'd0);
    chk("rst_fail", 72'(cal_fail), 72'd0);
    chk("rst_dvld", 72'(dvld),     72'd0);
    chk("rst_data", 72'(rd_data),  72'd0);
    chk("rst_err",  72'(err),      72'd0);

    // calibration: ready exactly 17 cycles after release
    rst = 1'b0;
    repeat (16) tick;
    chk("cal16_rdy",   72'(phy_rdy),    72'd0);
    chk("cal16_ffail", 72'(f_cal_fail), 72'd0);
    tick;
    chk("cal17_rdy",   72'(phy_rdy),    72'd1);
    chk("cal17_fail",  72'(cal_fail),   72'd0);
    chk("cal17_ffail", 72'(f_cal_fail), 72'd1);
    chk("cal17_frdy",  72'(f_phy_rdy),  72'd0);

    // full write / read
    wr_burst(22'd5, 36'h1_2345_6789, 4'hF, 36'hA_BCDE_F012, 4'hF);
    tick;
    rd_burst(22'd5, 36'h1_2345_6789, 36'hA_BCDE_F012, "a5");

    // lane enables: beat0 lanes 0 and 2 only, beat1 untouched
    wr_burst(22'd5, 36'hF_FFFF_FFFF, 4'b0101, 36'h0_0000_0000, 4'b0000);
    rd_burst(22'd5, 36'h1_27FD_67FF, 36'hA_BCDE_F012, "be");

    // aliasing: upper address bits ignored
    rd_burst(22'h3F_FC05, 36'h1_27FD_67FF, 36'hA_BCDE_F012, "alias");

    // back-to-back bursts, spacing 2
    wr_burst(22'd1, 36'h1_1111_1111, 4'hF, 36'h2_2222_2222, 4'hF);
    wr_burst(22'd2, 36'h3_3333_3333, 4'hF, 36'h4_4444_4444, 4'hF);
    rd_en = 1'b1; addr = 22'd1; tick;
    rd_en = 1'b0; tick;
    rd_en = 1'b1; addr = 22'd2; tick;
    rd_en = 1'b0;
    repeat (4) tick;
    chk("b2b_pre", 72'(dvld), 72'd0);
    tick; chk("b2b_dv0", 72'(dvld), 72'd1); chk("b2b_a1lo", 72'(rd_data), 72'h1_1111_1111);
    tick; chk("b2b_dv1", 72'(dvld), 72'd0); chk("b2b_a1hi", 72'(rd_data), 72'h2_2222_2222);
    tick; chk("b2b_dv2", 72'(dvld), 72'd1); chk("b2b_a2lo", 72'(rd_data), 72'h3_3333_3333);
    tick; chk("b2b_a2hi", 72'(rd_data), 72'h4_4444_4444);
    tick; chk("b2b_idle", 72'(rd_data), 72'd0);

    // spacing 1: second read dropped
    rd_en = 1'b1; addr = 22'd1; tick;
    addr = 22'd2; tick;
    rd_en = 1'b0;
    repeat (5) tick;
    chk("drop_err", 72'(err), 72'd1);
    tick; chk("drop_dv0", 72'(dvld), 72'd1); chk("drop_lo", 72'(rd_data), 72'h1_1111_1111);
    tick; chk("drop_hi", 72'(rd_data), 72'h2_2222_2222);
    tick; chk("drop_dv2", 72'(dvld), 72'd0); chk("drop_d2", 72'(rd_data), 72'd0);

    // wr_en during beat1: ignored, beat1 still commits
    wr_burst(22'd4, 36'h5_5555_5555, 4'hF, 36'h6_6666_6666, 4'hF);
    wr_en = 1'b1; addr = 22'd3; wr_data = 36'h7_7777_7777; wr_be = 4'hF; tick;
    addr = 22'd4; wr_data = 36'h8_8888_8888; tick;
    wr_en = 1'b0; wr_data = '0; wr_be = '0;
    chk("b1wr_err", 72'(err), 72'd2);
    rd_burst(22'd3, 36'h7_7777_7777, 36'h8_8888_8888, "a3");
    rd_burst(22'd4, 36'h5_5555_5555, 36'h6_6666_6666, "a4");

    // read and write same cycle: read returns pre-write data
    rd_en = 1'b1; wr_en = 1'b1; addr = 22'd3; wr_data = 36'h9_9999_9999; wr_be = 4'hF; tick;
    rd_en = 1'b0; wr_en = 1'b0; wr_data = 36'hC_CCCC_CCCC; tick;
    wr_data = '0; wr_be = '0;
    repeat (6) tick;
    chk("rw_dv0", 72'(dvld), 72'd1); chk("rw_lo", 72'(rd_data), 72'h7_7777_7777);
    tick; chk("rw_hi", 72'(rd_data), 72'h8_8888_8888);
    tick;
    rd_burst(22'd3, 36'h9_9999_9999, 36'hC_CCCC_CCCC, "rw_new");
    chk("rw_err", 72'(err), 72'd2);

    // reset mid-read, commands during re-calibration
    rd_en = 1'b1; addr = 22'd1; tick;
    rd_en = 1'b0;
    repeat (3) tick;
    rst = 1'b1; tick; tick;
    chk("mr_rdy", 72'(phy_rdy), 72'd0);
    chk("mr_err", 72'(err), 72'd0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = (i == 2); rd_en = (i == 4); addr = 22'd1;
      wr_data = 36'hF_FFFF_FFFF; wr_be = 4'hF;
      tick;
      if (dvld) nd++;
    end
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; wr_be = '0;
    chk("mr_nodvld", 72'(nd), 72'd0);
    chk("mr_err2", 72'(err), 72'd2);
    chk("mr_rdy16", 72'(phy_rdy), 72'd0);
    wt = 0;
    while (!phy_rdy && wt < 20) begin
      tick;
      wt++;
    end
    chk("mr_recal", 72'(wt), 72'd1);
    rd_burst(22'd1, 36'h1_1111_1111, 36'h2_2222_2222, "mr_keep");

    chk("f_err",  72'(f_err),     72'd0);
    chk("f_dvld", 72'(f_dvld),    72'd0);
    chk("f_data", 72'(f_rd_data), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
